piarb_qm_ctrl: RTL and testbench

PIARB_QM_CTRL -- requirements
Module: piarb_qm_ctrl

---
 rtl/meta_package.sv | 25 ++
 rtl/piarb_qm_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_piarb_qm_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/meta_package.sv
// Shared types for the PU queue manager: payload type and controller FSM states.
`ifndef PU_QUEUE_ENTRIES_NBITS
`define PU_QUEUE_ENTRIES_NBITS 4
`endif
`ifndef NUM_OF_PU
`define NUM_OF_PU 8
`endif

package meta_package;

  localparam int unsigned PU_PAYLOAD_NBITS = 16;

  typedef logic [PU_PAYLOAD_NBITS-1:0] pu_queue_payload_type;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ENQ_RD,
    ENQ_WR,
    DEQ_RD1,
    DEQ_RD2,
    DEQ_WR
  } piarb_qm_state_type;

endpackage

// File: rtl/piarb_qm_ctrl.sv
// Linked-list queue manager controller: builds the free list at init, then
// serves enqueue/dequeue requests against external head/tail/depth/ll/desc RAMs.
`ifndef PU_QUEUE_ENTRIES_NBITS
`define PU_QUEUE_ENTRIES_NBITS 4
`endif
`ifndef NUM_OF_PU
`define NUM_OF_PU 8
`endif

module piarb_qm_ctrl
  import meta_package::*;
#(
  parameter int QUEUE_ID_NBITS      = 5,
  parameter int QUEUE_ENTRIES_NBITS = `PU_QUEUE_ENTRIES_NBITS,
  parameter int QUEUE_DEPTH         = `NUM_OF_PU
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enq_req,
  input  logic [QUEUE_ID_NBITS-1:0]      enq_qid,
  input  pu_queue_payload_type           enq_data,
  output logic                           enq_ack,
  output logic                           enq_full,
  input  logic                           deq_req,
  input  logic [QUEUE_ID_NBITS-1:0]      deq_qid,
  output logic                           deq_ack,
  output logic                           deq_empty,
  output pu_queue_payload_type           deq_data,
  output logic                           init_done,
  output logic                           head_wr,
  output logic [QUEUE_ID_NBITS-1:0]      head_raddr,
  output logic [QUEUE_ID_NBITS-1:0]      head_waddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] head_wdata,
  input  logic [QUEUE_ENTRIES_NBITS-1:0] head_rdata,
  output logic                           tail_wr,
  output logic [QUEUE_ID_NBITS-1:0]      tail_raddr,
  output logic [QUEUE_ID_NBITS-1:0]      tail_waddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] tail_wdata,
  input  logic [QUEUE_ENTRIES_NBITS-1:0] tail_rdata,
  output logic                           depth_wr,
  output logic [QUEUE_ID_NBITS-1:0]      depth_raddr,
  output logic [QUEUE_ID_NBITS-1:0]      depth_waddr,
  output logic [QUEUE_ENTRIES_NBITS:0]   depth_wdata,
  input  logic [QUEUE_ENTRIES_NBITS:0]   depth_rdata,
  output logic                           depth_fid0_wr,
  output logic [QUEUE_ID_NBITS-1:0]      depth_fid0_raddr,
  output logic [QUEUE_ID_NBITS-1:0]      depth_fid0_waddr,
  output logic [QUEUE_ENTRIES_NBITS:0]   depth_fid0_wdata,
  output logic                           depth_fid1_wr,
  output logic [QUEUE_ID_NBITS-1:0]      depth_fid1_raddr,
  output logic [QUEUE_ID_NBITS-1:0]      depth_fid1_waddr,
  output logic [QUEUE_ENTRIES_NBITS:0]   depth_fid1_wdata,
  output logic                           ll_wr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] ll_raddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] ll_waddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] ll_wdata,
  input  logic [QUEUE_ENTRIES_NBITS-1:0] ll_rdata,
  output logic                           desc_wr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] desc_raddr,
  output logic [QUEUE_ENTRIES_NBITS-1:0] desc_waddr,
  output pu_queue_payload_type           desc_wdata,
  input  pu_queue_payload_type           desc_rdata
);

  localparam logic [QUEUE_ENTRIES_NBITS-1:0] LAST_IDX       = '1;
  localparam logic [QUEUE_ENTRIES_NBITS-1:0] FREE_TAIL_INIT = {{(QUEUE_ENTRIES_NBITS-1){1'b1}}, 1'b0};

  piarb_qm_state_type               state;
  logic [QUEUE_ENTRIES_NBITS-1:0]   init_idx;
  logic [QUEUE_ENTRIES_NBITS-1:0]   free_head;
  logic [QUEUE_ENTRIES_NBITS-1:0]   free_tail;
  logic [QUEUE_ENTRIES_NBITS:0]     free_cnt;
  logic                             last_deq;
  logic [QUEUE_ENTRIES_NBITS-1:0]   deq_head;
  logic [QUEUE_ENTRIES_NBITS:0]     deq_depth;

  // Secondary depth ports are unused by this controller.
  assign depth_fid0_wr    = 1'b0;
  assign depth_fid0_raddr = '0;
  assign depth_fid0_waddr = '0;
  assign depth_fid0_wdata = '0;
  assign depth_fid1_wr    = 1'b0;
  assign depth_fid1_raddr = '0;
  assign depth_fid1_waddr = '0;
  assign depth_fid1_wdata = '0;

  // Read addresses are decoded from the current state so the RAM's registered
  // read lands in the following state, giving 2-cycle enqueue / 3-cycle dequeue.
  always_comb begin
    head_raddr  = '0;
    tail_raddr  = '0;
    depth_raddr = '0;
    ll_raddr    = '0;
    desc_raddr  = '0;
    case (state)
      ENQ_RD: begin
        depth_raddr = enq_qid;
        tail_raddr  = enq_qid;
        ll_raddr    = free_head;
      end
      DEQ_RD1: begin
        head_raddr  = deq_qid;
        depth_raddr = deq_qid;
      end
      DEQ_RD2: begin
        ll_raddr    = head_rdata;
        desc_raddr  = head_rdata;
      end
      default: ;
    endcase
  end

  // Controller FSM with registered acks, write strobes and free-list pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      init_idx    <= '0;
      init_done   <= 1'b0;
      enq_ack     <= 1'b0;
      enq_full    <= 1'b0;
      deq_ack     <= 1'b0;
      deq_empty   <= 1'b0;
      deq_data    <= '0;
      head_wr     <= 1'b0;
      head_waddr  <= '0;
      head_wdata  <= '0;
      tail_wr     <= 1'b0;
      tail_waddr  <= '0;
      tail_wdata  <= '0;
      depth_wr    <= 1'b0;
      depth_waddr <= '0;
      depth_wdata <= '0;
      ll_wr       <= 1'b0;
      ll_waddr    <= '0;
      ll_wdata    <= '0;
      desc_wr     <= 1'b0;
      desc_waddr  <= '0;
      desc_wdata  <= '0;
      free_head   <= '0;
      free_tail   <= '0;
      free_cnt    <= '0;
      last_deq    <= 1'b1;
      deq_head    <= '0;
      deq_depth   <= '0;
    end else begin
      enq_ack   <= 1'b0;
      enq_full  <= 1'b0;
      deq_ack   <= 1'b0;
      deq_empty <= 1'b0;
      head_wr   <= 1'b0;
      tail_wr   <= 1'b0;
      depth_wr  <= 1'b0;
      ll_wr     <= 1'b0;
      desc_wr   <= 1'b0;
      case (state)
        INIT: begin
          ll_wr    <= 1'b1;
          ll_waddr <= init_idx;
          ll_wdata <= init_idx + 1'b1;
          if (int'(init_idx) < QUEUE_DEPTH) begin
            depth_wr    <= 1'b1;
            depth_waddr <= QUEUE_ID_NBITS'(init_idx);
            depth_wdata <= '0;
          end
          init_idx <= init_idx + 1'b1;
          if (init_idx == LAST_IDX) begin
            state     <= IDLE;
            init_done <= 1'b1;
            free_head <= '0;
            free_tail <= FREE_TAIL_INIT;
            free_cnt  <= {1'b0, LAST_IDX};
          end
        end
        IDLE: begin
          // Skip the ack cycle so a request still held during its own ack is not re-served.
          if (init_done && !enq_ack && !deq_ack) begin
            if (enq_req && (!deq_req || last_deq)) begin
              state    <= ENQ_RD;
              last_deq <= 1'b0;
            end else if (deq_req) begin
              state    <= DEQ_RD1;
              last_deq <= 1'b1;
            end
          end
        end
        ENQ_RD: begin
          if (free_cnt == '0) begin
            enq_ack  <= 1'b1;
            enq_full <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= ENQ_WR;
          end
        end
        ENQ_WR: begin
          desc_wr    <= 1'b1;
          desc_waddr <= free_head;
          desc_wdata <= enq_data;
          if (depth_rdata == '0) begin
            head_wr    <= 1'b1;
            head_waddr <= enq_qid;
            head_wdata <= free_head;
          end else begin
            ll_wr    <= 1'b1;
            ll_waddr <= tail_rdata;
            ll_wdata <= free_head;
          end
          tail_wr     <= 1'b1;
          tail_waddr  <= enq_qid;
          tail_wdata  <= free_head;
          depth_wr    <= 1'b1;
          depth_waddr <= enq_qid;
          depth_wdata <= depth_rdata + 1'b1;
          free_head   <= ll_rdata;
          free_cnt    <= free_cnt - 1'b1;
          enq_ack     <= 1'b1;
          state       <= IDLE;
        end
        DEQ_RD1: state <= DEQ_RD2;
        DEQ_RD2: begin
          if (depth_rdata == '0) begin
            deq_ack   <= 1'b1;
            deq_empty <= 1'b1;
            state     <= IDLE;
          end else begin
            deq_head  <= head_rdata;
            deq_depth <= depth_rdata;
            state     <= DEQ_WR;
          end
        end
        DEQ_WR: begin
          head_wr     <= 1'b1;
          head_waddr  <= deq_qid;
          head_wdata  <= ll_rdata;
          depth_wr    <= 1'b1;
          depth_waddr <= deq_qid;
          depth_wdata <= deq_depth - 1'b1;
          if (free_cnt == '0) begin
            free_head <= deq_head;
          end else begin
            ll_wr    <= 1'b1;
            ll_waddr <= free_tail;
            ll_wdata <= deq_head;
          end
          free_tail <= deq_head;
          free_cnt  <= free_cnt + 1'b1;
          deq_data  <= desc_rdata;
          deq_ack   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_piarb_qm_ctrl.sv
// Bench for piarb_qm_ctrl: behavioural RAMs around the DUT and a per-queue
// FIFO reference model driven by directed and random enqueue/dequeue traffic.
module tb_piarb_qm_ctrl;
  import meta_package::*;

  localparam int QID  = 5;
  localparam int QE   = 4;
  localparam int QD   = 8;
  localparam int E    = 1 << QE;
  localparam int CAP  = E - 1;
  localparam int NQA  = 1 << QID;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enq_req = 1'b0, deq_req = 1'b0;
  logic [QID-1:0] enq_qid = '0, deq_qid = '0;
  pu_queue_payload_type enq_data = '0;
  logic enq_ack, enq_full, deq_ack, deq_empty, init_done;
  pu_queue_payload_type deq_data;
  logic head_wr, tail_wr, depth_wr, ll_wr, desc_wr;
  logic [QID-1:0] head_raddr, head_waddr, tail_raddr, tail_waddr, depth_raddr, depth_waddr;
  logic [QE-1:0] head_wdata, head_rdata, tail_wdata, tail_rdata;
  logic [QE:0] depth_wdata, depth_rdata;
  logic depth_fid0_wr, depth_fid1_wr;
  logic [QID-1:0] depth_fid0_raddr, depth_fid0_waddr, depth_fid1_raddr, depth_fid1_waddr;
  logic [QE:0] depth_fid0_wdata, depth_fid1_wdata;
  logic [QE-1:0] ll_raddr, ll_waddr, ll_wdata, ll_rdata, desc_raddr, desc_waddr;
  pu_queue_payload_type desc_wdata, desc_rdata;

  logic [QE-1:0] head_mem [NQA];
  logic [QE-1:0] tail_mem [NQA];
  logic [QE:0]   depth_mem [NQA];
  logic [QE-1:0] ll_mem [E];
  pu_queue_payload_type desc_mem [E];

  int checks = 0;
  int errors = 0;

  pu_queue_payload_type mq [QD][$];
  int used = 0;
  bit last_was_deq = 1'b1;
  pu_queue_payload_type last_deq_data = '0;

  piarb_qm_ctrl #(.QUEUE_ID_NBITS(QID), .QUEUE_ENTRIES_NBITS(QE), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .enq_req(enq_req), .enq_qid(enq_qid), .enq_data(enq_data),
    .enq_ack(enq_ack), .enq_full(enq_full),
    .deq_req(deq_req), .deq_qid(deq_qid),
    .deq_ack(deq_ack), .deq_empty(deq_empty), .deq_data(deq_data),
    .init_done(init_done),
    .head_wr(head_wr), .head_raddr(head_raddr), .head_waddr(head_waddr),
    .head_wdata(head_wdata), .head_rdata(head_rdata),
    .tail_wr(tail_wr), .tail_raddr(tail_raddr), .tail_waddr(tail_waddr),
    .tail_wdata(tail_wdata), .tail_rdata(tail_rdata),
    .depth_wr(depth_wr), .depth_raddr(depth_raddr), .depth_waddr(depth_waddr),
    .depth_wdata(depth_wdata), .depth_rdata(depth_rdata),
    .depth_fid0_wr(depth_fid0_wr), .depth_fid0_raddr(depth_fid0_raddr),
    .depth_fid0_waddr(depth_fid0_waddr), .depth_fid0_wdata(depth_fid0_wdata),
    .depth_fid1_wr(depth_fid1_wr), .depth_fid1_raddr(depth_fid1_raddr),
    .depth_fid1_waddr(depth_fid1_waddr), .depth_fid1_wdata(depth_fid1_wdata),
    .ll_wr(ll_wr), .ll_raddr(ll_raddr), .ll_waddr(ll_waddr),
    .ll_wdata(ll_wdata), .ll_rdata(ll_rdata),
    .desc_wr(desc_wr), .desc_raddr(desc_raddr), .desc_waddr(desc_waddr),
    .desc_wdata(desc_wdata), .desc_rdata(desc_rdata)
  );

  always #5 clk = ~clk;

  // Data-structure RAMs with one-cycle registered read.
  always @(posedge clk) begin
    if (head_wr)  head_mem[head_waddr]   <= head_wdata;
    if (tail_wr)  tail_mem[tail_waddr]   <= tail_wdata;
    if (depth_wr) depth_mem[depth_waddr] <= depth_wdata;
    if (ll_wr)    ll_mem[ll_waddr]       <= ll_wdata;
    if (desc_wr)  desc_mem[desc_waddr]   <= desc_wdata;
    head_rdata  <= head_mem[head_raddr];
    tail_rdata  <= tail_mem[tail_raddr];
    depth_rdata <= depth_mem[depth_raddr];
    ll_rdata    <= ll_mem[ll_raddr];
    desc_rdata  <= desc_mem[desc_raddr];
  end

  task automatic do_enq(input int q, input pu_queue_payload_type d);
    int n;
    bit got;
    bit exp_full;
    exp_full = (used == CAP);
    @(negedge clk);
    enq_req = 1'b1; enq_qid = QID'(q); enq_data = d;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (enq_ack) got = 1'b1;
    end
    enq_req = 1'b0;
    checks++;
    assert (got === 1'b1) else begin errors++; $error("FAIL enq_timeout q=%0d observed=no_ack expected=ack", q); end
    if (got) begin
      checks++;
      assert (enq_full === exp_full) else begin errors++; $error("FAIL enq_full q=%0d observed=%0b expected=%0b", q, enq_full, exp_full); end
      checks++;
      assert (n === (exp_full ? 2 : 3)) else begin errors++; $error("FAIL enq_latency q=%0d observed=%0d expected=%0d", q, n, exp_full ? 2 : 3); end
      if (!exp_full) begin mq[q].push_back(d); used++; end
      last_was_deq = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_deq(input int q);
    int n;
    bit got;
    bit exp_empty;
    pu_queue_payload_type exp_d;
    exp_empty = (mq[q].size() == 0);
    exp_d = exp_empty ? last_deq_data : mq[q][0];
    @(negedge clk);
    deq_req = 1'b1; deq_qid = QID'(q);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (deq_ack) got = 1'b1;
    end
    deq_req = 1'b0;
    checks++;
    assert (got === 1'b1) else begin errors++; $error("FAIL deq_timeout q=%0d observed=no_ack expected=ack", q); end
    if (got) begin
      checks++;
      assert (deq_empty === exp_empty) else begin errors++; $error("FAIL deq_empty q=%0d observed=%0b expected=%0b", q, deq_empty, exp_empty); end
      checks++;
      assert (deq_data === exp_d) else begin errors++; $error("FAIL deq_data q=%0d observed=%h expected=%h", q, deq_data, exp_d); end
      checks++;
      assert (n === (exp_empty ? 3 : 4)) else begin errors++; $error("FAIL deq_latency q=%0d observed=%0d expected=%0d", q, n, exp_empty ? 3 : 4); end
      if (!exp_empty) begin void'(mq[q].pop_front()); used--; last_deq_data = exp_d; end
      last_was_deq = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    assert (n === E) else begin errors++; $error("FAIL init_cycles observed=%0d expected=%0d", n, E); end
  endtask

  initial begin
    pu_queue_payload_type da, db, dsim;
    int nacks, n;
    bit bad;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert ({init_done, enq_ack, enq_full, deq_ack, deq_empty} === 5'b0) else begin errors++; $error("FAIL reset_flags observed=%b expected=00000", {init_done, enq_ack, enq_full, deq_ack, deq_empty}); end
    checks++;
    assert (deq_data === '0) else begin errors++; $error("FAIL reset_deq_data observed=%h expected=0", deq_data); end
    checks++;
    assert ({head_wr, tail_wr, depth_wr, ll_wr, desc_wr, depth_fid0_wr, depth_fid1_wr} === 7'b0) else begin errors++; $error("FAIL reset_wr observed=%b expected=0", {head_wr, tail_wr, depth_wr, ll_wr, desc_wr, depth_fid0_wr, depth_fid1_wr}); end

    // Requests during init are ignored; init length and free-list links
    @(negedge clk);
    rst = 1'b0;
    enq_req = 1'b1; enq_qid = 5'd4; enq_data = 16'hdead;
    wait_init();
    enq_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    assert (enq_ack === 1'b0) else begin errors++; $error("FAIL early_req observed=%0b expected=0", enq_ack); end
    checks++;
    assert (ll_mem[5] === 4'd6) else begin errors++; $error("FAIL ll5 observed=%0d expected=6", ll_mem[5]); end
    checks++;
    assert (depth_fid0_wdata === '0 && depth_fid1_waddr === '0) else begin errors++; $error("FAIL fid_tie observed=%0d expected=0", depth_fid0_wdata); end

    // Simultaneous requests on different queues alternate, enqueue first
    dsim = 16'($urandom);
    @(negedge clk);
    enq_req = 1'b1; enq_qid = 5'd1; enq_data = dsim;
    deq_req = 1'b1; deq_qid = 5'd2;
    nacks = 0; n = 0;
    while (nacks < 6 && n < 300) begin
      @(negedge clk); n++;
      if (enq_ack || deq_ack) begin
        checks++;
        assert (enq_ack !== deq_ack && enq_ack === last_was_deq) else begin errors++; $error("FAIL alt_order ack=%0d observed=enq%0b/deq%0b expected_enq=%0b", nacks, enq_ack, deq_ack, last_was_deq); end
        if (enq_ack) begin
          checks++;
          assert (enq_full === (used == CAP)) else begin errors++; $error("FAIL alt_enq_full observed=%0b expected=%0b", enq_full, used == CAP); end
          if (used < CAP) begin mq[1].push_back(dsim); used++; end
          last_was_deq = 1'b0;
        end else begin
          checks++;
          assert (deq_empty === 1'b1) else begin errors++; $error("FAIL alt_deq_empty observed=%0b expected=1", deq_empty); end
          last_was_deq = 1'b1;
        end
        nacks++;
      end
    end
    enq_req = 1'b0; deq_req = 1'b0;
    checks++;
    assert (nacks === 6) else begin errors++; $error("FAIL alt_timeout observed=%0d expected=6", nacks); end
    @(negedge clk);
    repeat (3) do_deq(1);

    // FIFO order on one queue, then empty
    da = 16'h0a0a; db = 16'h0b0b;
    do_enq(3, da);
    do_enq(3, db);
    do_deq(3);
    do_deq(3);
    do_deq(3);

    // Fill to capacity, overflow, then recover one slot
    while (used < CAP) do_enq(int'($urandom_range(0, QD-1)), 16'($urandom));
    do_enq(6, 16'h1234);
    do_enq(0, 16'h5678);
    for (int q = 0; q < QD; q++) if (mq[q].size() != 0) begin do_deq(q); break; end
    do_enq(7, 16'h9abc);
    do_enq(7, 16'h9abd);

    // Random traffic
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 99) < 52) do_enq(int'($urandom_range(0, QD-1)), 16'($urandom));
      else do_deq(int'($urandom_range(0, QD-1)));
    end

    // Reset during DEQ_WR abandons the dequeue
    do_enq(0, 16'hcafe);
    @(negedge clk);
    deq_req = 1'b1; deq_qid = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bad = 1'b0;
    repeat (3) begin @(negedge clk); if (deq_ack) bad = 1'b1; end
    deq_req = 1'b0;
    checks++;
    assert (bad === 1'b0) else begin errors++; $error("FAIL rst_deq_ack observed=1 expected=0"); end
    for (int q = 0; q < QD; q++) mq[q].delete();
    used = 0; last_was_deq = 1'b1; last_deq_data = '0;
    rst = 1'b0;
    wait_init();
    @(negedge clk);
    for (int q = 0; q < QD; q++) do_deq(q);
    do_enq(5, 16'h0f0f);
    do_deq(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
